feed_forward_nn: RTL and testbench



---
 rtl/ffnn_pkg.sv | 51 +++++
 rtl/ffnn_mac.sv | 36 +++
 rtl/feed_forward_nn.sv | 155 +++++++++++++++
 tb/tb_feed_forward_nn.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ffnn_pkg.sv
// ffnn_pkg: shared constants, fixed weights and saturation helpers for the
// 4-3-2 feed-forward network core (feed_forward_nn) and its MAC (ffnn_mac).
//   N_IN/N_HID/N_OUT : layer sizes
//   FRAME            : cycles per time-multiplexed inference frame
//   W, B             : hidden-layer weights and biases
//   V, C             : output-layer weights and biases
//   sat9, sat17      : clamps to the hidden-activation and output ranges
package ffnn_pkg;

    localparam int N_IN   = 4;
    localparam int N_HID  = 3;
    localparam int N_OUT  = 2;
    localparam int FRAME  = 9;
    localparam int DATA_W = 9;
    localparam int COEF_W = 8;
    localparam int OUT_W  = 17;

    localparam logic signed [COEF_W-1:0] W [N_HID][N_IN] = '{
        '{ 8'sd1,  8'sd1, 8'sd1,  8'sd1},
        '{ 8'sd1, -8'sd1, 8'sd1, -8'sd1},
        '{ 8'sd2,  8'sd0, 8'sd0, -8'sd2}
    };
    localparam logic signed [COEF_W-1:0] B [N_HID] = '{8'sd0, 8'sd0, 8'sd0};

    localparam logic signed [COEF_W-1:0] V [N_OUT][N_HID] = '{
        '{8'sd1,  8'sd1, 8'sd1},
        '{8'sd1, -8'sd1, 8'sd0}
    };
    localparam logic signed [COEF_W-1:0] C [N_OUT] = '{8'sd0, 8'sd0};

    // Hidden activation range is [0,255]; carried as 9 bits so it can feed
    // the signed 9-bit MAC operand without a sign problem.
    function automatic logic [DATA_W-1:0] sat9(input longint v);
        if (v > 64'sd255)
            return 9'd255;
        else if (v < 64'sd0)
            return 9'd0;
        else
            return v[DATA_W-1:0];
    endfunction

    function automatic logic signed [OUT_W-1:0] sat17(input longint v);
        if (v > 64'sd65535)
            return 17'sd65535;
        else if (v < -64'sd65536)
            return -17'sd65536;
        else
            return v[OUT_W-1:0];
    endfunction

endpackage

// File: rtl/ffnn_mac.sv
// ffnn_mac: signed multiply-accumulate, a (DATA_W) x b (COEF_W) into ACC_W.
//   CLK, RST : clock, synchronous active-high reset (clears acc)
//   clr      : synchronous clear of acc (has priority over en)
//   en       : acc <= acc + a*b
//   a, b     : signed operands
//   acc      : signed running sum
module ffnn_mac #(
    parameter int DATA_W = 9,
    parameter int COEF_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [PROD_W-1:0] prod;

    assign prod = a * b;

    always_ff @(posedge CLK) begin
        if (RST)
            acc <= '0;
        else if (clr)
            acc <= '0;
        else if (en)
            acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end

endmodule

// File: rtl/feed_forward_nn.sv
// feed_forward_nn: fixed-weight 4-3-2 network (ReLU hidden, linear output),
// time-multiplexed over a free-running 9-cycle frame.
//   CLK, RST   : clock, synchronous active-high reset
//   x0..x3     : signed 9-bit input features, latched at cnt==0
//   y0, y1     : signed 17-bit outputs, updated at cnt==0, held otherwise
//   y_valid    : (only with `define FFNN_VALID_EN) one-cycle pulse after
//                each real y update
// Frame schedule (cnt):
//   0    : y <= sat17(oacc + C) (skipped on first frame), latch x, clear hacc
//   1..4 : hacc_j += W[j][cnt-1] * xr[cnt-1]
//   5    : h_j <= sat9(relu(hacc_j + B_j) >>> SHIFT), clear oacc
//   6..8 : oacc_k += V[k][cnt-6] * h[cnt-6]
module feed_forward_nn
    import ffnn_pkg::*;
#(
    parameter int ACC_W = 24,
    parameter int SHIFT = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic signed [DATA_W-1:0] x0,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic signed [DATA_W-1:0] x3,
    output logic signed [OUT_W-1:0]  y0,
    output logic signed [OUT_W-1:0]  y1
`ifdef FFNN_VALID_EN
    ,
    output logic                     y_valid
`endif
);

    logic [3:0]               cnt;
    // Set once a full frame has been computed since reset; gates the first
    // (meaningless) output update.
    logic                     primed;
    logic signed [DATA_W-1:0] xr [N_IN];
    logic [DATA_W-1:0]        h [N_HID];
    logic signed [ACC_W-1:0]  hacc [N_HID];
    logic signed [ACC_W-1:0]  oacc [N_OUT];
    logic [DATA_W-1:0]        h_next [N_HID];
    logic signed [OUT_W-1:0]  y_next [N_OUT];

    logic                     h_clr, h_en, o_clr, o_en;
    logic [3:0]               cnt_m1;
    logic [1:0]               idx_h;
    logic [1:0]               idx_o;
    logic signed [DATA_W-1:0] a_o;

    assign h_clr  = (cnt == 4'd0);
    assign h_en   = (cnt >= 4'd1) && (cnt <= 4'd4);
    assign o_clr  = (cnt == 4'd5);
    assign o_en   = (cnt >= 4'd6);
    assign cnt_m1 = cnt - 4'd1;
    assign idx_h  = cnt_m1[1:0];

    always_comb begin
        idx_o = 2'd0;
        case (cnt)
            4'd6:    idx_o = 2'd0;
            4'd7:    idx_o = 2'd1;
            4'd8:    idx_o = 2'd2;
            default: idx_o = 2'd0;
        endcase
    end

    // h is in [0,255], so reinterpreting it as signed 9-bit is lossless.
    assign a_o = $signed(h[idx_o]);

    for (genvar j = 0; j < N_HID; j++) begin : g_hid
        ffnn_mac #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .ACC_W  (ACC_W)
        ) u_mac (
            .CLK (CLK),
            .RST (RST),
            .clr (h_clr),
            .en  (h_en),
            .a   (xr[idx_h]),
            .b   (W[j][idx_h]),
            .acc (hacc[j])
        );

        always_comb begin
            longint pre;
            longint relu;
            pre       = longint'(hacc[j]) + longint'(B[j]);
            relu      = (pre < 64'sd0) ? 64'sd0 : pre;
            h_next[j] = sat9(relu >>> SHIFT);
        end
    end

    for (genvar k = 0; k < N_OUT; k++) begin : g_out
        ffnn_mac #(
            .DATA_W (DATA_W),
            .COEF_W (COEF_W),
            .ACC_W  (ACC_W)
        ) u_mac (
            .CLK (CLK),
            .RST (RST),
            .clr (o_clr),
            .en  (o_en),
            .a   (a_o),
            .b   (V[k][idx_o]),
            .acc (oacc[k])
        );

        assign y_next[k] = sat17(longint'(oacc[k]) + longint'(C[k]));
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt    <= 4'd0;
            primed <= 1'b0;
            y0     <= '0;
            y1     <= '0;
            for (int i = 0; i < N_IN; i++)
                xr[i] <= '0;
            for (int j = 0; j < N_HID; j++)
                h[j] <= '0;
        end else begin
            cnt <= (cnt == 4'(FRAME - 1)) ? 4'd0 : cnt + 4'd1;

            if (cnt == 4'd0) begin
                if (primed) begin
                    y0 <= y_next[0];
                    y1 <= y_next[1];
                end
                xr[0] <= x0;
                xr[1] <= x1;
                xr[2] <= x2;
                xr[3] <= x3;
            end

            if (cnt == 4'd5) begin
                for (int j = 0; j < N_HID; j++)
                    h[j] <= h_next[j];
            end

            if (cnt == 4'(FRAME - 1))
                primed <= 1'b1;
        end
    end

`ifdef FFNN_VALID_EN
    always_ff @(posedge CLK) begin
        if (RST)
            y_valid <= 1'b0;
        else
            y_valid <= (cnt == 4'd0) && primed;
    end
`endif

endmodule

// File: tb/tb_feed_forward_nn.sv
// tb_feed_forward_nn: directed and random checks of feed_forward_nn.
// Build with `define FFNN_VALID_EN to also exercise y_valid.
module tb_feed_forward_nn;

    logic               CLK = 1'b0;
    logic               RST;
    logic signed [8:0]  x0, x1, x2, x3;
    logic signed [16:0] y0, y1;
`ifdef FFNN_VALID_EN
    logic               y_valid;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    feed_forward_nn #(
        .ACC_W (24),
        .SHIFT (0)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .x0  (x0),
        .x1  (x1),
        .x2  (x2),
        .x3  (x3),
        .y0  (y0),
        .y1  (y1)
`ifdef FFNN_VALID_EN
        ,
        .y_valid (y_valid)
`endif
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic set_x(input int a, input int b, input int c, input int d);
        x0 = 9'(a);
        x1 = 9'(b);
        x2 = 9'(c);
        x3 = 9'(d);
    endtask

    // Reference network written independently from the weight table.
    function automatic int sat9m(input int v);
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic int sat17m(input int v);
        if (v < -65536) return -65536;
        if (v > 65535)  return 65535;
        return v;
    endfunction

    task automatic model(input int a, input int b, input int c, input int d,
                         output int e0, output int e1);
        int h0, h1, h2;
        h0 = sat9m(a + b + c + d);
        h1 = sat9m(a - b + c - d);
        h2 = sat9m(2 * a - 2 * d);
        e0 = sat17m(h0 + h1 + h2);
        e1 = sat17m(h0 - h1);
    endtask

    task automatic test_reset;
        RST = 1'b1;
        set_x(0, 0, 0, 0);
        tick(2);
        n_checks++;
        if (y0 !== 17'sd0 || y1 !== 17'sd0) begin
            n_fail++;
            $display("FAIL reset_y: y0=%0d y1=%0d expected 0 0", y0, y1);
        end
        n_checks++;
        if (dut.cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: cnt=%0d expected 0", dut.cnt);
        end
`ifdef FFNN_VALID_EN
        n_checks++;
        if (y_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid: y_valid=%0b expected 0", y_valid);
        end
`endif
        RST = 1'b0;
        set_x(1, 2, 3, 4);
        for (int i = 0; i < 9; i++) begin
            tick(1);
            n_checks++;
            if (y0 !== 17'sd0 || y1 !== 17'sd0) begin
                n_fail++;
                $display("FAIL first_frame_hold c%0d: y0=%0d y1=%0d expected 0 0", i, y0, y1);
            end
`ifdef FFNN_VALID_EN
            n_checks++;
            if (y_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL first_frame_valid c%0d: y_valid=%0b expected 0", i, y_valid);
            end
`endif
        end
    endtask

    task automatic test_basic;
        set_x(1, 2, 3, 4);
        tick(24);
        n_checks++;
        if (dut.h[0] !== 9'd10 || dut.h[1] !== 9'd0 || dut.h[2] !== 9'd0) begin
            n_fail++;
            $display("FAIL basic_h: h=(%0d,%0d,%0d) expected (10,0,0)", dut.h[0], dut.h[1], dut.h[2]);
        end
        n_checks++;
        if (y0 !== 17'sd10 || y1 !== 17'sd10) begin
            n_fail++;
            $display("FAIL basic_y: y0=%0d y1=%0d expected 10 10", y0, y1);
        end
    endtask

    task automatic test_single;
        set_x(10, 0, 0, 0);
        tick(24);
        n_checks++;
        if (dut.h[0] !== 9'd10 || dut.h[1] !== 9'd10 || dut.h[2] !== 9'd20) begin
            n_fail++;
            $display("FAIL single_h: h=(%0d,%0d,%0d) expected (10,10,20)", dut.h[0], dut.h[1], dut.h[2]);
        end
        n_checks++;
        if (y0 !== 17'sd40 || y1 !== 17'sd0) begin
            n_fail++;
            $display("FAIL single_y: y0=%0d y1=%0d expected 40 0", y0, y1);
        end
    endtask

    task automatic test_sat_high;
        set_x(255, 255, 255, 255);
        tick(24);
        n_checks++;
        if (dut.h[0] !== 9'd255 || dut.h[1] !== 9'd0 || dut.h[2] !== 9'd0) begin
            n_fail++;
            $display("FAIL sat_h: h=(%0d,%0d,%0d) expected (255,0,0)", dut.h[0], dut.h[1], dut.h[2]);
        end
        n_checks++;
        if (y0 !== 17'sd255 || y1 !== 17'sd255) begin
            n_fail++;
            $display("FAIL sat_y: y0=%0d y1=%0d expected 255 255", y0, y1);
        end
    endtask

    task automatic test_relu_clamp;
        set_x(-256, -256, -256, -256);
        tick(24);
        n_checks++;
        if (dut.h[0] !== 9'd0 || dut.h[1] !== 9'd0 || dut.h[2] !== 9'd0) begin
            n_fail++;
            $display("FAIL relu_h: h=(%0d,%0d,%0d) expected (0,0,0)", dut.h[0], dut.h[1], dut.h[2]);
        end
        n_checks++;
        if (y0 !== 17'sd0 || y1 !== 17'sd0) begin
            n_fail++;
            $display("FAIL relu_y: y0=%0d y1=%0d expected 0 0", y0, y1);
        end
    endtask

    // Inputs switch right after the frame latched x=-256; that frame must
    // still produce 0, and only the following frame reflects the new x.
    task automatic test_hold_midframe;
        int guard;
        guard = 0;
        while (dut.cnt !== 4'd1 && guard < 20) begin
            tick(1);
            guard++;
        end
        n_checks++;
        if (dut.cnt !== 4'd1) begin
            n_fail++;
            $display("FAIL hold_sync: cnt=%0d expected 1 within 20 cycles", dut.cnt);
        end
        set_x(10, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            n_checks++;
            if (y0 !== 17'sd0 || y1 !== 17'sd0) begin
                n_fail++;
                $display("FAIL hold_old c%0d: y0=%0d y1=%0d expected 0 0", i, y0, y1);
            end
        end
        tick(1);
        n_checks++;
        if (y0 !== 17'sd0 || y1 !== 17'sd0) begin
            n_fail++;
            $display("FAIL hold_inflight: y0=%0d y1=%0d expected 0 0", y0, y1);
        end
        tick(9);
        n_checks++;
        if (y0 !== 17'sd40 || y1 !== 17'sd0) begin
            n_fail++;
            $display("FAIL hold_new: y0=%0d y1=%0d expected 40 0", y0, y1);
        end
    endtask

    task automatic test_reset_midframe;
        int guard;
        guard = 0;
        while (dut.cnt !== 4'd4 && guard < 20) begin
            tick(1);
            guard++;
        end
        n_checks++;
        if (dut.cnt !== 4'd4) begin
            n_fail++;
            $display("FAIL rstmid_sync: cnt=%0d expected 4 within 20 cycles", dut.cnt);
        end
        RST = 1'b1;
        tick(1);
        n_checks++;
        if (y0 !== 17'sd0 || y1 !== 17'sd0 || dut.cnt !== 4'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear: y0=%0d y1=%0d cnt=%0d expected 0 0 0", y0, y1, dut.cnt);
        end
        RST = 1'b0;
        tick(9);
        n_checks++;
        if (y0 !== 17'sd0 || y1 !== 17'sd0) begin
            n_fail++;
            $display("FAIL rstmid_skip: y0=%0d y1=%0d expected 0 0", y0, y1);
        end
`ifdef FFNN_VALID_EN
        n_checks++;
        if (y_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_skip_valid: y_valid=%0b expected 0", y_valid);
        end
`endif
        tick(1);
        n_checks++;
        if (y0 !== 17'sd40 || y1 !== 17'sd0) begin
            n_fail++;
            $display("FAIL rstmid_update: y0=%0d y1=%0d expected 40 0", y0, y1);
        end
`ifdef FFNN_VALID_EN
        n_checks++;
        if (y_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_valid: y_valid=%0b expected 1", y_valid);
        end
`endif
    endtask

`ifdef FFNN_VALID_EN
    task automatic test_valid;
        int pulses;
        pulses = 0;
        for (int i = 0; i < 90; i++) begin
            tick(1);
            if (y_valid === 1'b1) begin
                pulses++;
                n_checks++;
                if (dut.cnt !== 4'd1) begin
                    n_fail++;
                    $display("FAIL valid_phase: cnt=%0d at pulse expected 1", dut.cnt);
                end
            end
        end
        n_checks++;
        if (pulses != 10) begin
            n_fail++;
            $display("FAIL valid_count: pulses=%0d expected 10 in 90 cycles", pulses);
        end
    endtask
`endif

    task automatic test_random;
        int a, b, c, d, e0, e1;
        for (int n = 0; n < 100; n++) begin
            a = int'($urandom_range(0, 511)) - 256;
            b = int'($urandom_range(0, 511)) - 256;
            c = int'($urandom_range(0, 511)) - 256;
            d = int'($urandom_range(0, 511)) - 256;
            set_x(a, b, c, d);
            model(a, b, c, d, e0, e1);
            tick(24);
            n_checks++;
            if (y0 !== 17'(e0) || y1 !== 17'(e1)) begin
                n_fail++;
                $display("FAIL random v%0d x=(%0d,%0d,%0d,%0d): y0=%0d y1=%0d expected %0d %0d",
                         n, a, b, c, d, y0, y1, e0, e1);
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        set_x(0, 0, 0, 0);
        test_reset;
        test_basic;
        test_single;
        test_sat_high;
        test_relu_clamp;
        test_hold_midframe;
        test_reset_midframe;
`ifdef FFNN_VALID_EN
        test_valid;
`endif
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
